// File: rtl/axilite_m.sv
// axilite_m: single-outstanding AXI4-Lite master.
// Command/response front end with a per-phase watchdog.
module axilite_m #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_aresetn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,

    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [ADDR_W-1:0] m_axi_awaddr,

    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [DATA_W-1:0] m_axi_wdata,

    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic [1:0]        m_axi_bresp,

    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [ADDR_W-1:0] m_axi_araddr,

    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_I =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              cmd_ready_q;
    logic              cmd_ready_d;
    logic              awvalid_q;
    logic              awvalid_d;
    logic              wvalid_q;
    logic              wvalid_d;
    logic              bready_q;
    logic              bready_d;
    logic              arvalid_q;
    logic              arvalid_d;
    logic              rready_q;
    logic              rready_d;
    logic [ADDR_W-1:0] awaddr_q;
    logic [ADDR_W-1:0] awaddr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic [ADDR_W-1:0] araddr_q;
    logic [ADDR_W-1:0] araddr_d;

    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic              rsp_write_q;
    logic              rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic [1:0]        rsp_resp_q;
    logic [1:0]        rsp_resp_d;
    logic              rsp_timeout_q;
    logic              rsp_timeout_d;

    logic              wd_exp;
    logic              aw_ok;
    logic              w_ok;
    logic              abort;

    // Expiry lands on the last cycle of a phase of TIMEOUT_CYCLES cycles.
    assign wd_exp = (TIMEOUT_CYCLES > 0) && (cnt_q == LAST);

    // A channel counts as done once its valid has dropped or fires now.
    assign aw_ok = !awvalid_q || m_axi_awready;
    assign w_ok  = !wvalid_q  || m_axi_wready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        araddr_d      = araddr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d   = 1'b0;
                    cnt_d         = '0;
                    rsp_write_d   = cmd_write;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = 2'b00;
                    rsp_timeout_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR_AW_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                    end else begin
                        state_d   = RD_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = cmd_addr;
                    end
                end
            end

            WR_AW_W: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_ok && w_ok) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                    cnt_d    = '0;
                end else if (wd_exp) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WR_B: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (wd_exp) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RD_AR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = RD_R;
                end else if (wd_exp) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RD_R: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (wd_exp) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog abort releases the bus and reports a SLVERR.
        if (abort) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            cnt_d         = '0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            state_d       = RSP;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            araddr_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            araddr_q      <= araddr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axilite_m.sv
// tb_axilite_m: randomized scoreboard bench for axilite_m
// with a behavioural AXI4-Lite slave memory and watchdog cases.
module tb_axilite_m;

    localparam int T    = 8;
    localparam int H_NO = 0;
    localparam int H_AW = 1;
    localparam int H_W  = 2;
    localparam int H_B  = 3;
    localparam int H_AR = 4;
    localparam int H_R  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready;
    logic        bvalid, bready, arvalid, arready;
    logic        rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axilite_m #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)
    ) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_awaddr(awaddr),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_wdata(wdata),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_bresp(bresp),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_araddr(araddr),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        bit          to;
        int          lat;
        int          aw_n, w_n, b_n, ar_n, r_n;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem_r [0:255];
    logic [31:0] mem_s [0:255];
    int          c_aw, c_w, c_b, c_ar, c_r, c_hang;

    function automatic bit is_err(input logic [31:0] a);
        return (a >= 32'd200) && (a < 32'd208);
    endfunction

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     nm, act, exp);
        end
    endtask

    // Behavioural slave: ready/valid decided just after each edge.
    initial begin : slave
        bit          aw_got, w_got, wrote, b_done, ar_got, r_done;
        int          aw_k, w_k, b_k, ar_k, r_k;
        logic [31:0] s_aw, s_w, s_ar;
        for (int i = 0; i < 256; i++) mem_s[i] = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        aw_got = 0; w_got = 0; wrote = 0; b_done = 0;
        ar_got = 0; r_done = 0;
        aw_k = 0; w_k = 0; b_k = 0; ar_k = 0; r_k = 0;
        s_aw = 0; s_w = 0; s_ar = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || cmd_ready) begin
                aw_got = 0; w_got = 0; wrote = 0; b_done = 0;
                ar_got = 0; r_done = 0;
                aw_k = 0; w_k = 0; b_k = 0; ar_k = 0; r_k = 0;
                awready = 0; wready = 0; bvalid = 0;
                arready = 0; rvalid = 0;
            end else begin
                if (awvalid && !aw_got && c_hang != H_AW
                    && aw_k >= c_aw) begin
                    awready = 1; aw_got = 1; s_aw = awaddr;
                end else begin
                    awready = 0;
                    if (awvalid) aw_k++;
                end
                if (wvalid && !w_got && c_hang != H_W
                    && w_k >= c_w) begin
                    wready = 1; w_got = 1; s_w = wdata;
                end else begin
                    wready = 0;
                    if (wvalid) w_k++;
                end
                if (aw_got && w_got && !wrote) begin
                    wrote = 1;
                    if (!is_err(s_aw)) mem_s[s_aw[7:0]] = s_w;
                end
                if (bvalid) begin
                    bvalid = 0;
                end else if (aw_got && w_got && bready && !b_done
                             && c_hang != H_B) begin
                    if (b_k >= c_b) begin
                        bvalid = 1; b_done = 1;
                        bresp = is_err(s_aw) ? 2'b11 : 2'b00;
                    end else begin
                        b_k++;
                    end
                end
                if (arvalid && !ar_got && c_hang != H_AR
                    && ar_k >= c_ar) begin
                    arready = 1; ar_got = 1; s_ar = araddr;
                end else begin
                    arready = 0;
                    if (arvalid) ar_k++;
                end
                if (rvalid) begin
                    rvalid = 0;
                end else if (ar_got && rready && !r_done
                             && c_hang != H_R) begin
                    if (r_k >= c_r) begin
                        rvalid = 1; r_done = 1;
                        rresp = is_err(s_ar) ? 2'b11 : 2'b00;
                        rdata = is_err(s_ar) ? '0 : mem_s[s_ar[7:0]];
                    end else begin
                        r_k++;
                    end
                end
            end
        end
    end

    initial begin : rsp_drv
        rsp_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: samples on the falling edge and pops the scoreboard.
    int cyc = 0;
    int acc_cyc = 0;
    bit in_txn = 0;
    bit seen_rv = 0;
    int m_aw, m_w, m_b, m_ar, m_r;

    always @(negedge clk) begin : monitor
        exp_t e;
        cyc++;
        if (!rst_n) begin
            in_txn = 0;
            seen_rv = 0;
        end else begin
            if (awvalid || wvalid || bready || arvalid || rready)
                check("bus_exclusive",
                      32'((awvalid || wvalid || bready)
                          && (arvalid || rready)), 0);
            if (in_txn && exp_q.size() > 0) begin
                e = exp_q[0];
                if (awvalid) begin
                    m_aw++; check("awaddr", awaddr, e.addr);
                end
                if (wvalid) begin
                    m_w++; check("wdata", wdata, e.wdata);
                end
                if (bready) m_b++;
                if (arvalid) begin
                    m_ar++; check("araddr", araddr, e.addr);
                end
                if (rready) m_r++;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", 32'(rsp_valid), 0);
                end else begin
                    e = exp_q[0];
                    if (!seen_rv) begin
                        seen_rv = 1;
                        check("latency", cyc - acc_cyc, e.lat);
                    end
                    if (rsp_ready) begin
                        check("rsp_write", 32'(rsp_write), 32'(e.wr));
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                        check("rsp_timeout", 32'(rsp_timeout),
                              32'(e.to));
                        check("aw_cycles", m_aw, e.aw_n);
                        check("w_cycles", m_w, e.w_n);
                        check("b_cycles", m_b, e.b_n);
                        check("ar_cycles", m_ar, e.ar_n);
                        check("r_cycles", m_r, e.r_n);
                        void'(exp_q.pop_front());
                        in_txn = 0;
                        seen_rv = 0;
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                in_txn = 1;
                acc_cyc = cyc;
                m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
            end
        end
    end

    // Reference model: phase lengths and results from the slave rules.
    function automatic exp_t model(input bit wr,
                                   input logic [31:0] a,
                                   input logic [31:0] d);
        exp_t e;
        int   l1;
        bit   hw;
        e.wr = wr; e.addr = a; e.wdata = d;
        e.to = (c_hang != H_NO);
        e.resp = e.to ? 2'b10 : (is_err(a) ? 2'b11 : 2'b00);
        e.rdata = '0;
        e.aw_n = 0; e.w_n = 0; e.b_n = 0; e.ar_n = 0; e.r_n = 0;
        if (wr) begin
            hw = (c_hang == H_AW) || (c_hang == H_W);
            e.aw_n = (c_hang == H_AW) ? T : c_aw + 1;
            e.w_n  = (c_hang == H_W)  ? T : c_w + 1;
            l1 = hw ? T : ((c_aw > c_w) ? c_aw : c_w) + 1;
            e.b_n = hw ? 0 : ((c_hang == H_B) ? T : c_b + 1);
            e.lat = 1 + l1 + e.b_n;
            if (!hw && !is_err(a)) mem_r[a[7:0]] = d;
        end else begin
            e.ar_n = (c_hang == H_AR) ? T : c_ar + 1;
            e.r_n = (c_hang == H_AR) ? 0
                  : ((c_hang == H_R) ? T : c_r + 1);
            e.lat = 1 + e.ar_n + e.r_n;
            if (!e.to && !is_err(a)) e.rdata = mem_r[a[7:0]];
        end
        return e;
    endfunction

    task automatic issue(input bit wr, input logic [31:0] a,
                         input logic [31:0] d,
                         input int awd, input int wd, input int bd,
                         input int ard, input int rd, input int hg);
        int t;
        @(posedge clk);
        #1;
        cmd_valid = 1; cmd_write = wr;
        cmd_addr = a; cmd_wdata = d;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) begin
            check("cmd_accept_wait", 32'(cmd_ready), 1);
            cmd_valid = 0;
            return;
        end
        c_aw = awd; c_w = wd; c_b = bd;
        c_ar = ard; c_r = rd; c_hang = hg;
        exp_q.push_back(model(wr, a, d));
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    initial begin : main
        bit          wr;
        logic [31:0] a, d;
        int          hg, t;
        for (int i = 0; i < 256; i++) mem_r[i] = '0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
        c_hang = H_NO;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_bready", 32'(bready), 0);
        check("rst_arvalid", 32'(arvalid), 0);
        check("rst_rready", 32'(rready), 0);
        rst_n = 1;

        issue(1, 32'h5, 32'hDEADBEEF, 0, 0, 0, 0, 0, H_NO);
        issue(0, 32'h5, 32'h0, 0, 0, 0, 0, 0, H_NO);
        issue(1, 32'h10, 32'h1234_5678, 3, 0, 0, 0, 0, H_NO);
        issue(1, 32'd200, 32'hCAFE_F00D, 0, 0, 0, 0, 0, H_NO);
        issue(0, 32'd200, 32'h0, 0, 0, 0, 0, 0, H_NO);
        issue(0, 32'h7, 32'h0, 0, 0, 0, 0, 0, H_AR);
        issue(0, 32'h10, 32'h0, 0, 0, 0, 1, 2, H_NO);

        issue(1, 32'h9, 32'h0BAD_0BAD, 0, 0, 0, 0, 0, H_B);
        t = 0;
        while (!bready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reach_wr_b", 32'(bready), 1);
        rst_n = 0;
        #1;
        check("arst_bready", 32'(bready), 0);
        check("arst_rsp_valid", 32'(rsp_valid), 0);
        check("arst_awvalid", 32'(awvalid), 0);
        check("arst_wvalid", 32'(wvalid), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);
        issue(0, 32'h9, 32'h0, 0, 0, 0, 0, 0, H_NO);

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                a = 32'd200 + $urandom_range(0, 7);
            else
                a = $urandom_range(0, 31);
            d = $urandom;
            hg = H_NO;
            if ($urandom_range(0, 9) == 0)
                hg = wr ? $urandom_range(1, 3) : $urandom_range(4, 5);
            issue(wr, a, d,
                  $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), hg);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0)
            check("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
